// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution multiply-accumulate datapath.
package conv_pkg;

   localparam int PROD_W = 32;
   localparam int SUM_W  = 32;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/conv_mac_accumulator_if.sv
// Product-in / window-sum-out handshake bundle of conv_mac_accumulator.
interface conv_mac_accumulator_if;
   import conv_pkg::*;

   logic [PROD_W-1:0] prod_i;
   logic              prod_valid_i;
   logic              prod_ready_o;
   logic [SUM_W-1:0]  sum_o;
   logic              sum_valid_o;
   logic              sum_ready_i;
   logic              ovf_o;
   logic [7:0]        tap_o;

   modport slave (
      input  prod_i, prod_valid_i, sum_ready_i,
      output prod_ready_o, sum_o, sum_valid_o, ovf_o, tap_o
   );

   modport master (
      output prod_i, prod_valid_i, sum_ready_i,
      input  prod_ready_o, sum_o, sum_valid_o, ovf_o, tap_o
   );

endinterface

// File: rtl/conv_acc_sat.sv
// Wide accumulator to 32-bit result: overflow detect, plus clamp when
// CONV_ACC_SATURATE_EN is defined (plain truncation otherwise).
module conv_acc_sat
   import conv_pkg::*;
#(
   parameter int ACC_W = 40
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [SUM_W-1:0] sum_o,
   output logic             ovf_o
);

   assign ovf_o = |acc_i[ACC_W-1:SUM_W];

`ifdef CONV_ACC_SATURATE_EN
   assign sum_o = ovf_o ? '1 : acc_i[SUM_W-1:0];
`else
   assign sum_o = acc_i[SUM_W-1:0];
`endif

endmodule

// File: rtl/conv_mac_accumulator.sv
// Streaming accumulate of KERNEL_LEN products per window with a held result.
// Output clamping is selected by CONV_ACC_SATURATE_EN (see conv_acc_sat).
module conv_mac_accumulator
   import conv_pkg::*;
#(
   parameter int KERNEL_LEN = 9,   // 2..255
   parameter int ACC_W      = 40   // >= 32 + clog2(KERNEL_LEN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   conv_mac_accumulator_if.slave  bus
);

   localparam logic [7:0] LAST_TAP = 8'(KERNEL_LEN - 1);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [7:0]       tap_q, tap_d;
   logic [SUM_W-1:0] sum_q, sum_d, sat_sum;
   logic             ovf_q, ovf_d, sat_ovf;
   logic             beat, last_beat;

   assign beat      = bus.prod_valid_i && (state_q == ACCUM);
   assign last_beat = beat && (tap_q == LAST_TAP);

   // Tap 0 loads instead of adding, so a new window needs no clear cycle.
   assign acc_sum = (tap_q == '0) ? ACC_W'(bus.prod_i) : acc_q + ACC_W'(bus.prod_i);
   assign acc_d   = beat ? acc_sum : acc_q;

   // Result is formatted from the next accumulator value so it lands in
   // the output register on the same edge as the last tap.
   conv_acc_sat #(.ACC_W(ACC_W)) u_sat (
      .acc_i (acc_sum),
      .sum_o (sat_sum),
      .ovf_o (sat_ovf)
   );

   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d = state_q;
      tap_d   = tap_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      if (beat) tap_d = last_beat ? '0 : tap_q + 8'd1;
      if (last_beat) begin
         state_d = HOLD;
         sum_d   = sat_sum;
         ovf_d   = sat_ovf;
      end else if (state_q == HOLD && bus.sum_ready_i) begin
         state_d = ACCUM;
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         tap_q   <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         tap_q   <= tap_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

   // prod_ready_o is decoded from state alone, never from sum_ready_i.
   assign bus.prod_ready_o = (state_q == ACCUM);
   assign bus.sum_valid_o  = (state_q == HOLD);
   assign bus.sum_o        = sum_q;
   assign bus.ovf_o        = ovf_q;
   assign bus.tap_o        = tap_q;

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Self-checking bench for conv_mac_accumulator: directed table, reset and
// streaming corner cases, then random windows against a window-sum model.
module tb_conv_mac_accumulator;
   import conv_pkg::*;

   localparam int K     = 9;
   localparam int ACC_W = 40;

`ifdef CONV_ACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef logic [31:0] win_t [K];

   typedef struct {
      logic [31:0] base;
      logic [31:0] stp;
      int          gap;     // 0 back-to-back, 1 valid pattern 1,0,0
      int          hold;    // backpressure cycles before accepting
      logic [31:0] exp_sum;
      logic        exp_ovf;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   conv_mac_accumulator_if bus ();

   conv_mac_accumulator #(.KERNEL_LEN(K), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: a window result is the plain sum of its products.
   task automatic ref_window(input win_t v, output logic [31:0] s, output logic o);
      longint unsigned total = 0;
      for (int i = 0; i < K; i++) total += longint'(v[i]);
      o = (total >> 32) != 0;
      s = (SAT && o) ? 32'hFFFF_FFFF : total[31:0];
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(bus.prod_ready_o), 64'd1);
      check({tag, "_valid"}, 64'(bus.sum_valid_o), 64'd0);
      check({tag, "_sum"},   64'(bus.sum_o), 64'd0);
      check({tag, "_ovf"},   64'(bus.ovf_o), 64'd0);
      check({tag, "_tap"},   64'(bus.tap_o), 64'd0);
   endtask

   // Drive one window; gap 2 means random valid gaps. If ack is clear the
   // DUT is left in HOLD with the result pending.
   task automatic feed(input win_t v, input int gap, input int hold, input bit ack,
                       input string tag, output logic [31:0] s, output logic o);
      int  i   = 0;
      int  cyc = 0;
      bit  drv;
      while (i < K && cyc < 200) begin
         drv = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         bus.prod_valid_i = drv;
         bus.prod_i       = drv ? v[i] : $urandom;
         check({tag, "_tap"},   64'(bus.tap_o), 64'(i));
         check({tag, "_ready"}, 64'(bus.prod_ready_o), 64'd1);
         step();
         if (drv) i++;
         cyc++;
      end
      bus.prod_valid_i = 1'b0;
      check({tag, "_valid_lat"}, 64'(bus.sum_valid_o), 64'd1);
      check({tag, "_tap_wrap"},  64'(bus.tap_o), 64'd0);
      s = bus.sum_o;
      o = bus.ovf_o;
      for (int h = 0; h < hold; h++) begin
         bus.prod_valid_i = 1'b1;
         bus.prod_i       = $urandom;
         bus.sum_ready_i  = 1'b0;
         step();
         check({tag, "_bp_ready"}, 64'(bus.prod_ready_o), 64'd0);
         check({tag, "_bp_valid"}, 64'(bus.sum_valid_o), 64'd1);
         check({tag, "_bp_sum"},   64'(bus.sum_o), 64'(s));
         check({tag, "_bp_ovf"},   64'(bus.ovf_o), 64'(o));
      end
      bus.prod_valid_i = 1'b0;
      if (ack) begin
         bus.sum_ready_i = 1'b1;
         check({tag, "_ack_ready"}, 64'(bus.prod_ready_o), 64'd0);
         step();
         bus.sum_ready_i = 1'b0;
         check({tag, "_post_valid"}, 64'(bus.sum_valid_o), 64'd0);
         check({tag, "_post_ready"}, 64'(bus.prod_ready_o), 64'd1);
      end
   endtask

   vec_t        tbl [6];
   win_t        w;
   logic [31:0] got_s, exp_s;
   logic        got_o, exp_o;

   initial begin
      tbl[0] = '{32'd1000,       32'd0, 0, 5, 32'd9000, 1'b0};
      tbl[1] = '{32'hFFFF_FFFF,  32'd0, 0, 0, SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFF7, 1'b1};
      tbl[2] = '{32'd0,          32'd0, 0, 1, 32'd0, 1'b0};
      tbl[3] = '{32'd1,          32'd1, 1, 0, 32'd45, 1'b0};
      tbl[4] = '{32'h2000_0000,  32'd0, 0, 2, SAT ? 32'hFFFF_FFFF : 32'h2000_0000, 1'b1};
      tbl[5] = '{32'h1C71_C71C,  32'd0, 0, 1, 32'hFFFF_FFFC, 1'b0};

      bus.prod_i       = '0;
      bus.prod_valid_i = 1'b0;
      bus.sum_ready_i  = 1'b0;
      #12;
      check_reset_outputs("por");
      rst_n = 1'b1;
      step();

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < K; i++) w[i] = tbl[t].base + 32'(i) * tbl[t].stp;
         feed(w, tbl[t].gap, tbl[t].hold, 1'b1, $sformatf("vec%0d", t), got_s, got_o);
         check($sformatf("vec%0d_sum", t), 64'(got_s), 64'(tbl[t].exp_sum));
         check($sformatf("vec%0d_ovf", t), 64'(got_o), 64'(tbl[t].exp_ovf));
      end

      // Mid-window reset: partial sum must not leak into the next window.
      for (int i = 0; i < 4; i++) begin
         bus.prod_valid_i = 1'b1;
         bus.prod_i       = 32'hFFFF_FFFF;
         step();
      end
      bus.prod_valid_i = 1'b0;
      check("mid_tap_before_rst", 64'(bus.tap_o), 64'd4);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      step();
      check_reset_outputs("mid_rst_hold");
      rst_n = 1'b1;
      step();
      for (int i = 0; i < K; i++) w[i] = 32'd2;
      feed(w, 0, 0, 1'b1, "after_rst", got_s, got_o);
      check("after_rst_sum", 64'(got_s), 64'd18);
      check("after_rst_ovf", 64'(got_o), 64'd0);

      // Reset while a result is pending drops it immediately.
      for (int i = 0; i < K; i++) w[i] = 32'd7;
      feed(w, 0, 0, 1'b0, "hold_rst", got_s, got_o);
      check("hold_rst_sum", 64'(got_s), 64'd63);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("hold_rst");
      step();
      rst_n = 1'b1;
      step();

      // Back-to-back: sum_ready tied high, 27 beats -> three results, one bubble each.
      begin
         logic [31:0] acc_vals [$];
         int          accepted = 0;
         int          results  = 0;
         int          cyc      = 0;
         win_t        ww;
         bus.sum_ready_i = 1'b1;
         while (results < 3 && cyc < 100) begin
            check("b2b_ready_vs_valid", 64'(bus.prod_ready_o), 64'(!bus.sum_valid_o));
            if (bus.sum_valid_o) begin
               for (int i = 0; i < K; i++) ww[i] = acc_vals[results * K + i];
               ref_window(ww, exp_s, exp_o);
               check($sformatf("b2b_sum%0d", results), 64'(bus.sum_o), 64'(exp_s));
               check($sformatf("b2b_ovf%0d", results), 64'(bus.ovf_o), 64'(exp_o));
               results++;
            end
            bus.prod_valid_i = (accepted < 3 * K);
            bus.prod_i       = $urandom;
            if (bus.prod_valid_i && bus.prod_ready_o) begin
               acc_vals.push_back(bus.prod_i);
               accepted++;
            end
            step();
            cyc++;
         end
         bus.prod_valid_i = 1'b0;
         bus.sum_ready_i  = 1'b0;
         check("b2b_results", 64'(results), 64'd3);
         check("b2b_cycles",  64'(cyc), 64'(3 * (K + 1)));
         step();
         check("b2b_idle_valid", 64'(bus.sum_valid_o), 64'd0);
      end

      // Random windows against the model.
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i < K; i++)
            w[i] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 100000));
         ref_window(w, exp_s, exp_o);
         feed(w, 2, $urandom_range(0, 3), 1'b1, $sformatf("rnd%0d", r), got_s, got_o);
         check($sformatf("rnd%0d_sum", r), 64'(got_s), 64'(exp_s));
         check($sformatf("rnd%0d_ovf", r), 64'(got_o), 64'(exp_o));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_mac_accumulator.md
# conv_mac_accumulator

Sequential accumulate stage directly downstream of the 16x16 Vedic multiplier in the convolution datapath. Takes one 32-bit unsigned product per accepted beat and sums KERNEL_LEN consecutive products into a wide accumulator. It then presents the window sum on a valid/ready output port, holding it until the consumer accepts. This turns the combinational multiplier into a streaming multiply-accumulate for one convolution output pixel per window.

## Interface
- KERNEL_LEN, 9, products per window (3x3 kernel); legal range 2..255.
- ACC_W, 40, accumulator width; must be ≥ 32 + clog2(KERNEL_LEN).
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- prod_i  in  32  unsigned product from the multiplier.
- prod_valid_i  in  1  prod_i valid this cycle.
- prod_ready_o  out  1  block accepts prod_i this cycle.
- sum_o  out  32  window result, output format per Configuration.
- sum_valid_o  out  1  sum_o valid.
- sum_ready_i  in  1  consumer accepts sum_o.
- ovf_o  out  1  accumulator exceeded 32 bits in the presented window; qualified by sum_valid_o.
- tap_o  out  8  index of the next product to be accepted, 0..KERNEL_LEN-1.

## Operation
- A beat is accepted when prod_valid_i && prod_ready_o.
- FSM has two states, ACCUM and HOLD. Reset state is ACCUM.
- In ACCUM:
  - prod_ready_o = 1.
  - On an accepted beat with tap_o == 0: acc ← zero-extended prod_i. No separate clear cycle.
  - On an accepted beat with tap_o > 0: acc ← acc + prod_i, taken modulo 2^ACC_W.
  - Every accepted beat increments tap_o.
  - On the beat with tap_o == KERNEL_LEN-1: tap_o wraps to 0, and the FSM moves to HOLD with the final sum registered.
- In HOLD:
  - prod_ready_o = 0. sum_valid_o = 1.
  - sum_o and ovf_o are stable until the handshake completes.
  - When sum_ready_i = 1, the FSM returns to ACCUM on the next edge.
- No-beat cycles leave acc and tap_o unchanged. Gaps inside a window are legal.
- ovf_o = |acc[ACC_W-1:32] for the presented window.
- sum_ready_i is ignored outside HOLD.
- The multiplier is combinational, so prod_i must be stable only while prod_valid_i is high.

## Timing
- Reset values: prod_ready_o=1, sum_valid_o=0, sum_o=0, ovf_o=0, tap_o=0, acc=0, state=ACCUM.
- Latency: if the last tap is accepted at edge N, sum_valid_o is high from N to the acceptance edge.
- Throughput: one window per KERNEL_LEN+1 cycles minimum. The HOLD cycle is a mandatory bubble, and no product is accepted while a result is pending.
- HOLD with sum_ready_i=1 exits in one cycle. prod_ready_o rises in the following cycle, not combinationally.
- Reset asserted mid-window or in HOLD discards the partial sum or pending result immediately and asynchronously, and returns to the reset values above.
- All outputs are registered except prod_ready_o, which is decoded from state only and never from sum_ready_i.

## Configuration
- CONV_ACC_SATURATE_EN defined:
  - If ovf_o = 1, sum_o = 32'hFFFF_FFFF.
  - Otherwise, sum_o = acc[31:0].
- CONV_ACC_SATURATE_EN undefined:
  - sum_o = acc[31:0] (wrap).
  - ovf_o is still reported.
- Accumulator width and handshake are identical in both builds.

## Structure
- Shared package conv_pkg holds:
  - the state enum (ACCUM, HOLD);
  - the product width constant PROD_W = 32;
  - the output width constant SUM_W = 32.
- One natural sub-module: conv_acc_sat, a combinational ACC_W→32 clamp/truncate plus overflow detect.
  - Its clamp path is compiled under the macro.
- FSM, tap counter and accumulator live in the top.

## Test plan
- **Single window:** reset, KERNEL_LEN=9, nine beats of prod_i=1000 back-to-back.
  - Expect sum_o=9000, ovf_o=0, sum_valid_o the edge after the 9th beat.
  - Expect tap_o back to 0.
- **Backpressure:** hold sum_ready_i=0 for 5 cycles with prod_valid_i=1.
  - Expect prod_ready_o=0 and sum_o stable throughout.
  - After sum_ready_i=1, expect the next window to start cleanly from prod_i, with no leakage from the prior sum.
- **Overflow:** nine beats of 32'hFFFF_FFFF. acc=0x8_FFFF_FFF7, ovf_o=1.
  - With the macro: sum_o=32'hFFFF_FFFF.
  - Without the macro: sum_o=32'hFFFF_FFF7.
- **Gapped input:** valid toggled 1,0,0,1,… with values 1..9.
  - Expect sum_o=45. Expect tap_o to advance only on accepted beats.
- **Mid-window reset:** pulse rst_n low after 4 beats, then send a full window of prod_i=2.
  - Expect sum_o=18, not 18 plus the earlier partial.
  - Expect all outputs at reset values during reset.
- **Back-to-back windows:** sum_ready_i tied 1, 27 continuous valid beats of value k.
  - Expect exactly three results.
  - Expect one bubble cycle after each window.
